// File: rtl/csr_access_sequencer_if.sv
// Bundles the requester handshakes (core, debug) and the CSR file port of csr_access_sequencer.
// The slave modport is the sequencer's view; master is the requester/CSR-file side.
interface csr_access_sequencer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  core_req_valid;
  logic                  core_req_ready;
  logic [1:0]            core_req_op;
  logic [ADDR_WIDTH-1:0] core_req_address;
  logic [DATA_WIDTH-1:0] core_req_operand;
  logic                  core_rsp_valid;
  logic                  core_rsp_ready;
  logic [DATA_WIDTH-1:0] core_rsp_data;
  logic                  core_rsp_illegal;

  logic                  dbg_req_valid;
  logic                  dbg_req_ready;
  logic [1:0]            dbg_req_op;
  logic [ADDR_WIDTH-1:0] dbg_req_address;
  logic [DATA_WIDTH-1:0] dbg_req_operand;
  logic                  dbg_rsp_valid;
  logic                  dbg_rsp_ready;
  logic [DATA_WIDTH-1:0] dbg_rsp_data;
  logic                  dbg_rsp_illegal;

  logic [ADDR_WIDTH-1:0] csr_address;
  logic [DATA_WIDTH-1:0] csr_read_value;
  logic [DATA_WIDTH-1:0] csr_write_value;
  logic                  csr_write_enable;

  modport slave (
    input  core_req_valid, core_req_op, core_req_address, core_req_operand, core_rsp_ready,
    input  dbg_req_valid, dbg_req_op, dbg_req_address, dbg_req_operand, dbg_rsp_ready,
    input  csr_read_value,
    output core_req_ready, core_rsp_valid, core_rsp_data, core_rsp_illegal,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_illegal,
    output csr_address, csr_write_value, csr_write_enable
  );

  modport master (
    output core_req_valid, core_req_op, core_req_address, core_req_operand, core_rsp_ready,
    output dbg_req_valid, dbg_req_op, dbg_req_address, dbg_req_operand, dbg_rsp_ready,
    output csr_read_value,
    input  core_req_ready, core_rsp_valid, core_rsp_data, core_rsp_illegal,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data, dbg_rsp_illegal,
    input  csr_address, csr_write_value, csr_write_enable
  );
endinterface

// File: rtl/csr_access_sequencer.sv
// Atomic CSRRW/CSRRS/CSRRC sequencer sharing one CSR file port between core and debug requesters.
// Define CSR_SEQ_DEBUG_PORT_EN to let the debug port join round-robin arbitration.
module csr_access_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  csr_access_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam logic [1:0] OP_RES = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  state_t                r_state, w_next_state;
  logic                  r_owner;  // 1 = debug owns the access in flight
  logic [1:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [DATA_WIDTH-1:0] r_old;
  logic                  r_illegal;

  logic                  w_grant_core, w_grant_dbg, w_accept;
  logic [1:0]            w_req_op;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0] w_req_operand;
  logic [DATA_WIDTH-1:0] w_new;
  logic                  w_write_needed, w_illegal, w_rsp_done;

`ifdef CSR_SEQ_DEBUG_PORT_EN
  logic r_last_grant;  // 1 = debug was granted last

  always_comb begin
    if (bus.core_req_valid && bus.dbg_req_valid) begin
      w_grant_core = r_last_grant;
      w_grant_dbg  = !r_last_grant;
    end else begin
      w_grant_core = bus.core_req_valid;
      w_grant_dbg  = bus.dbg_req_valid;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_grant_dbg;
  end
`else
  logic w_unused_dbg_valid;
  assign w_unused_dbg_valid = bus.dbg_req_valid;
  assign w_grant_core       = bus.core_req_valid;
  assign w_grant_dbg        = 1'b0;
`endif

  assign w_accept      = (r_state == S_IDLE) && (w_grant_core || w_grant_dbg);
  assign w_req_op      = w_grant_dbg ? bus.dbg_req_op      : bus.core_req_op;
  assign w_req_addr    = w_grant_dbg ? bus.dbg_req_address : bus.core_req_address;
  assign w_req_operand = w_grant_dbg ? bus.dbg_req_operand : bus.core_req_operand;

  assign w_write_needed = (r_op == OP_RW) || (r_operand != '0);
  assign w_illegal      = w_write_needed && (r_addr[ADDR_WIDTH-1 -: 2] == 2'b11);
  assign w_rsp_done     = r_owner ? bus.dbg_rsp_ready : bus.core_rsp_ready;

  always_comb begin
    case (r_op)
      OP_RW:   w_new = r_operand;
      OP_RC:   w_new = r_old & ~r_operand;
      default: w_new = r_old | r_operand;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner   <= 1'b0;
      r_op      <= OP_RS;
      r_addr    <= '0;
      r_operand <= '0;
      r_old     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_owner <= w_grant_dbg;
          r_addr  <= w_req_addr;
          // The reserved encoding behaves as a set with a zero operand.
          if (w_req_op == OP_RES) begin
            r_op      <= OP_RS;
            r_operand <= '0;
          end else begin
            r_op      <= w_req_op;
            r_operand <= w_req_operand;
          end
        end
        S_READ:  r_old     <= bus.csr_read_value;
        S_WRITE: r_illegal <= w_illegal;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next_state         = r_state;
    bus.core_req_ready   = 1'b0;
    bus.dbg_req_ready    = 1'b0;
    bus.core_rsp_valid   = 1'b0;
    bus.core_rsp_data    = '0;
    bus.core_rsp_illegal = 1'b0;
    bus.dbg_rsp_valid    = 1'b0;
    bus.dbg_rsp_data     = '0;
    bus.dbg_rsp_illegal  = 1'b0;
    bus.csr_address      = '0;
    bus.csr_write_value  = '0;
    bus.csr_write_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.core_req_ready = w_grant_core;
        bus.dbg_req_ready  = w_grant_dbg;
        if (w_accept) w_next_state = S_READ;
      end
      S_READ: begin
        bus.csr_address = r_addr;
        w_next_state    = S_WRITE;
      end
      S_WRITE: begin
        bus.csr_address      = r_addr;
        bus.csr_write_value  = w_new;
        bus.csr_write_enable = w_write_needed && !w_illegal;
        w_next_state         = S_RESP;
      end
      S_RESP: begin
        bus.csr_address = r_addr;
        if (r_owner) begin
          bus.dbg_rsp_valid   = 1'b1;
          bus.dbg_rsp_data    = r_old;
          bus.dbg_rsp_illegal = r_illegal;
        end else begin
          bus.core_rsp_valid   = 1'b1;
          bus.core_rsp_data    = r_old;
          bus.core_rsp_illegal = r_illegal;
        end
        if (w_rsp_done) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_csr_access_sequencer.sv
// Self-checking bench for csr_access_sequencer: fixed vectors, a stall, a reset pulse,
// arbitration, and random accesses scored against an array model of the CSR file.
module tb_csr_access_sequencer;
`ifdef CSR_SEQ_DEBUG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  csr_access_sequencer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
  csr_access_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // CSR file stand-in: combinational read, write on the strobe, plus a preload path.
  logic [31:0] csr_mem [4096];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  assign bus.csr_read_value = csr_mem[bus.csr_address];
  always @(posedge clock) begin
    if (bus.csr_write_enable) csr_mem[bus.csr_address] <= bus.csr_write_value;
    else if (pre_en)          csr_mem[pre_addr] <= pre_data;
  end

  logic [31:0] model_mem [4096];
  int tests_run = 0;
  int tests_failed = 0;

  int          obs_we_cnt, obs_we_cycle, obs_rsp_cycle;
  logic [31:0] obs_we_val, obs_data;
  logic        obs_ill, obs_addr_bad, obs_other_rsp, obs_accepted;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] operand;
    logic [31:0] csr_val;
    logic        exp_we;
    logic [31:0] exp_wval;
    logic        exp_ill;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic set_req(input bit who, input logic v, input logic [1:0] op,
                         input logic [11:0] a, input logic [31:0] operand);
    if (!who) begin
      bus.core_req_valid = v; bus.core_req_op = op;
      bus.core_req_address = a; bus.core_req_operand = operand;
    end else begin
      bus.dbg_req_valid = v; bus.dbg_req_op = op;
      bus.dbg_req_address = a; bus.dbg_req_operand = operand;
    end
  endtask

  function automatic logic get_ready(input bit who);
    return who ? bus.dbg_req_ready : bus.core_req_ready;
  endfunction
  function automatic logic get_rsp_valid(input bit who);
    return who ? bus.dbg_rsp_valid : bus.core_rsp_valid;
  endfunction

  // One access: wait for acceptance (bounded), then watch cycles T+1.. until the owner's response.
  task automatic access(input bit who, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] operand);
    bit got;
    obs_we_cnt = 0; obs_we_val = '0; obs_we_cycle = -1; obs_rsp_cycle = -1;
    obs_data = '0; obs_ill = 1'b0; obs_addr_bad = 1'b0; obs_other_rsp = 1'b0;
    @(negedge clock);
    set_req(who, 1'b1, op, a, operand);
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (get_ready(who)) begin got = 1'b1; break; end
      @(negedge clock); #1;
    end
    obs_accepted = got;
    if (!got) set_req(who, 1'b0, 2'b00, '0, '0);
    else begin
      for (int k = 1; k <= 12; k++) begin
        @(negedge clock);
        if (k == 1) set_req(who, 1'b0, 2'b00, '0, '0);
        #1;
        if (bus.csr_address !== a) obs_addr_bad = 1'b1;
        if (bus.csr_write_enable === 1'b1) begin
          obs_we_cnt++; obs_we_val = bus.csr_write_value; obs_we_cycle = k;
        end
        if (get_rsp_valid(!who)) obs_other_rsp = 1'b1;
        if (get_rsp_valid(who)) begin
          obs_rsp_cycle = k;
          obs_data = who ? bus.dbg_rsp_data : bus.core_rsp_data;
          obs_ill  = who ? bus.dbg_rsp_illegal : bus.core_rsp_illegal;
          break;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1);
  end

  initial begin
    logic [11:0] addrs [8];
    logic [31:0] held;
    int order [6];
    int g, nc, nd, ncr, ndr, cur_owner;
    logic bad_owner, both_ready, saw_rsp, dbg_seen;

    vecs[0]  = '{2'b01, 12'h340, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{2'b10, 12'h300, 32'h0,        32'h00000088, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{2'b11, 12'hF14, 32'h1,        32'h0000ABCD, 1'b0, 32'h0,        1'b1};
    vecs[3]  = '{2'b10, 12'hF14, 32'h0,        32'h00001234, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{2'b10, 12'h305, 32'h000000F0, 32'h0000000F, 1'b1, 32'h000000FF, 1'b0};
    vecs[5]  = '{2'b11, 12'h341, 32'h000000FF, 32'h00001234, 1'b1, 32'h00001200, 1'b0};
    vecs[6]  = '{2'b00, 12'h340, 32'h0000FFFF, 32'h00000055, 1'b0, 32'h0,        1'b0};
    vecs[7]  = '{2'b01, 12'hC00, 32'h0,        32'h00000007, 1'b0, 32'h0,        1'b1};
    vecs[8]  = '{2'b01, 12'h7FF, 32'h0,        32'h00000009, 1'b1, 32'h0,        1'b0};
    vecs[9]  = '{2'b11, 12'h300, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b0};
    vecs[10] = '{2'b10, 12'hBFF, 32'h1,        32'h0,        1'b1, 32'h1,        1'b0};
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h7C0, 12'hBC0, 12'hC00, 12'hF14};

    set_req(1'b0, 1'b0, 2'b00, '0, '0);
    set_req(1'b1, 1'b0, 2'b00, '0, '0);
    bus.core_rsp_ready = 1'b1;
    bus.dbg_rsp_ready  = 1'b1;

    // Reset values, during and just after reset.
    repeat (3) @(negedge clock);
    check("rst core_req_ready", {31'b0, bus.core_req_ready}, 32'h0);
    check("rst dbg_req_ready", {31'b0, bus.dbg_req_ready}, 32'h0);
    check("rst core_rsp_valid", {31'b0, bus.core_rsp_valid}, 32'h0);
    check("rst dbg_rsp_valid", {31'b0, bus.dbg_rsp_valid}, 32'h0);
    check("rst rsp_illegal", {30'b0, bus.core_rsp_illegal, bus.dbg_rsp_illegal}, 32'h0);
    check("rst csr_write_enable", {31'b0, bus.csr_write_enable}, 32'h0);
    check("rst core_rsp_data", bus.core_rsp_data, 32'h0);
    check("rst csr_address", {20'b0, bus.csr_address}, 32'h0);
    check("rst csr_write_value", bus.csr_write_value, 32'h0);
    reset_n = 1'b1;
    @(negedge clock); #1;
    check("idle csr_address", {20'b0, bus.csr_address}, 32'h0);

    // Fixed vectors from the core port.
    for (int i = 0; i < 11; i++) begin
      preload(vecs[i].addr, vecs[i].csr_val);
      access(1'b0, vecs[i].op, vecs[i].addr, vecs[i].operand);
      check($sformatf("vec%0d accepted", i), {31'b0, obs_accepted}, 32'h1);
      check($sformatf("vec%0d we_count", i), obs_we_cnt, {31'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d we_value", i), obs_we_val, vecs[i].exp_wval);
        check($sformatf("vec%0d we_cycle", i), obs_we_cycle, 32'd2);
      end
      check($sformatf("vec%0d rsp_cycle", i), obs_rsp_cycle, 32'd3);
      check($sformatf("vec%0d rsp_data", i), obs_data, vecs[i].csr_val);
      check($sformatf("vec%0d rsp_illegal", i), {31'b0, obs_ill}, {31'b0, vecs[i].exp_ill});
      check($sformatf("vec%0d addr_bad", i), {31'b0, obs_addr_bad}, 32'h0);
      check($sformatf("vec%0d other_rsp", i), {31'b0, obs_other_rsp}, 32'h0);
    end

    // Response back-pressure: held for 5 cycles, no accept meanwhile.
    preload(12'h342, 32'hCAFEF00D);
    bus.core_rsp_ready = 1'b0;
    access(1'b0, 2'b11, 12'h342, 32'h000000F0);
    check("stall rsp_cycle", obs_rsp_cycle, 32'd3);
    held = obs_data;
    check("stall first data", held, 32'hCAFEF00D);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      set_req(1'b0, 1'b1, 2'b10, 12'h300, 32'h0);
      set_req(1'b1, DBG_EN, 2'b10, 12'h305, 32'h0);
      #1;
      check($sformatf("stall%0d rsp_valid", c), {31'b0, bus.core_rsp_valid}, 32'h1);
      check($sformatf("stall%0d rsp_data", c), bus.core_rsp_data, held);
      check($sformatf("stall%0d core_ready", c), {31'b0, bus.core_req_ready}, 32'h0);
      check($sformatf("stall%0d dbg_ready", c), {31'b0, bus.dbg_req_ready}, 32'h0);
    end
    @(negedge clock);
    set_req(1'b1, 1'b0, 2'b00, '0, '0);
    bus.core_rsp_ready = 1'b1;
    #1;
    check("stall release core_ready", {31'b0, bus.core_req_ready}, 32'h0);
    @(negedge clock); #1;
    check("post-stall rsp_valid", {31'b0, bus.core_rsp_valid}, 32'h0);
    check("post-stall core_ready", {31'b0, bus.core_req_ready}, 32'h1);
    set_req(1'b0, 1'b0, 2'b00, '0, '0);

    // Random accesses against the model.
    foreach (addrs[j]) preload(addrs[j], $urandom());
    for (int n = 0; n < 40; n++) begin
      bit who;
      logic [1:0] op;
      logic [11:0] a;
      logic [31:0] operand, old_v, new_v;
      logic need, ill;
      who = DBG_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 2'($urandom_range(0, 3));
      a = addrs[$urandom_range(0, 7)];
      operand = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      old_v = model_mem[a];
      need = (op == 2'b01) || (op != 2'b00 && operand != 0);
      if (op == 2'b01)      new_v = operand;
      else if (op == 2'b10) new_v = old_v | operand;
      else if (op == 2'b11) new_v = old_v & ~operand;
      else                  new_v = old_v;
      ill = need && (a >= 12'hC00);
      access(who, op, a, operand);
      check($sformatf("rnd%0d rsp_data", n), obs_data, old_v);
      check($sformatf("rnd%0d rsp_illegal", n), {31'b0, obs_ill}, {31'b0, ill});
      check($sformatf("rnd%0d we_count", n), obs_we_cnt, {31'b0, need && !ill});
      if (need && !ill) begin
        check($sformatf("rnd%0d we_value", n), obs_we_val, new_v);
        model_mem[a] = new_v;
      end
      check($sformatf("rnd%0d other_rsp", n), {31'b0, obs_other_rsp}, 32'h0);
    end

    // Reset pulse while the write strobe is high.
    preload(12'h340, 32'h11112222);
    @(negedge clock);
    set_req(1'b0, 1'b1, 2'b01, 12'h340, 32'h33334444);
    #1;
    check("rstpulse accept", {31'b0, bus.core_req_ready}, 32'h1);
    @(negedge clock);
    set_req(1'b0, 1'b0, 2'b00, '0, '0);
    @(negedge clock); #1;
    check("rstpulse we before", {31'b0, bus.csr_write_enable}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstpulse we dropped", {31'b0, bus.csr_write_enable}, 32'h0);
    check("rstpulse csr_address", {20'b0, bus.csr_address}, 32'h0);
    check("rstpulse csr_write_value", bus.csr_write_value, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clock); #1;
      if (bus.core_rsp_valid || bus.dbg_rsp_valid) saw_rsp = 1'b1;
    end
    check("rstpulse no rsp", {31'b0, saw_rsp}, 32'h0);
    check("rstpulse no write", csr_mem[12'h340], 32'h11112222);

    // Contended requests straight after reset.
    preload(12'h300, 32'h0000C0C0);
    preload(12'h7C0, 32'h0000DB6D);
    foreach (order[j]) order[j] = 2;
    g = 0; nc = 0; nd = 0; ncr = 0; ndr = 0; cur_owner = -1;
    bad_owner = 1'b0; both_ready = 1'b0; dbg_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      set_req(1'b0, nc < 3, 2'b10, 12'h300, 32'h0);
      set_req(1'b1, nd < 3, 2'b10, 12'h7C0, 32'h0);
      #1;
      if (bus.core_rsp_valid) begin
        ncr++;
        if (cur_owner != 0 || bus.core_rsp_data !== 32'h0000C0C0) bad_owner = 1'b1;
      end
      if (bus.dbg_rsp_valid) begin
        ndr++;
        if (cur_owner != 1 || bus.dbg_rsp_data !== 32'h0000DB6D) bad_owner = 1'b1;
      end
      if (bus.core_req_ready && bus.dbg_req_ready) both_ready = 1'b1;
      if (bus.dbg_req_ready) dbg_seen = 1'b1;
      if (bus.core_req_ready) begin
        if (g < 6) order[g] = 0;
        g++; nc++; cur_owner = 0;
      end else if (bus.dbg_req_ready) begin
        if (g < 6) order[g] = 1;
        g++; nd++; cur_owner = 1;
      end
    end
    set_req(1'b0, 1'b0, 2'b00, '0, '0);
    set_req(1'b1, 1'b0, 2'b00, '0, '0);
    check("arb both ready", {31'b0, both_ready}, 32'h0);
    check("arb rsp owner", {31'b0, bad_owner}, 32'h0);
    check("arb core responses", ncr, 32'd3);
    if (DBG_EN) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("arb grant%0d", i), order[i], i % 2);
      check("arb dbg responses", ndr, 32'd3);
    end else begin
      check("arb dbg never granted", {31'b0, dbg_seen}, 32'h0);
      check("arb dbg no responses", ndr, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/csr_access_sequencer.md
# csr_access_sequencer

Sequences all software-visible accesses to the machine-mode CSR file and shares its single read/write port between two requesters: the core's Zicsr execute path and a debug/host port. Each accepted request becomes an atomic read-modify-write (CSRRW/CSRRS/CSRRC semantics): the old value is returned to the requester, and at most one write strobe reaches the CSR file. The block sits between the core (and debug bridge) and the `csr` module's `address` / `read_value` / `write_value` / `write_enable` pins.

## Interface
- `ADDR_WIDTH`, 12: CSR address width.
- `DATA_WIDTH`, 32: CSR data width.

- `clock` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: reset, asynchronous and active-low. This is already decided.
- `core_req_valid` in 1: core request present.
- `core_req_ready` out 1: core request accepted when valid&&ready.
- `core_req_op` in 2: 01 RW, 10 RS (set), 11 RC (clear); 00 reserved, treated as RS with zero operand.
- `core_req_address` in ADDR_WIDTH: target CSR.
- `core_req_operand` in DATA_WIDTH: rs1/uimm value.
- `core_rsp_valid` out 1: response available.
- `core_rsp_ready` in 1: response consumed when valid&&ready.
- `core_rsp_data` out DATA_WIDTH: old CSR value.
- `core_rsp_illegal` out 1: write attempted to a read-only CSR.
- `dbg_req_*`, `dbg_rsp_*`: same set of ports as core, for the debug requester.
- `csr_address` out ADDR_WIDTH: to CSR file.
- `csr_read_value` in DATA_WIDTH: combinational read data from CSR file.
- `csr_write_value` out DATA_WIDTH: to CSR file.
- `csr_write_enable` out 1: one-cycle write strobe.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - `*_req_ready` is driven per the arbiter grant.
  - On handshake, latch requester id, op, address and operand; go to READ.
- Arbitration: round-robin on a `last_grant` bit.
  - If both requesters are valid, grant the one not granted last.
  - If only one is valid, grant it.
  - `last_grant` updates on each accepted request.
- READ:
  - Drive `csr_address` from the latched address.
  - Capture `csr_read_value` into `old_value`; go to WRITE.
- WRITE:
  - `new` = operand (RW); `old | operand` (RS); `old & ~operand` (RC).
  - `write_needed` = (op==RW) or (operand != 0).
  - `illegal` = write_needed and address[11:10]==2'b11.
  - Assert `csr_write_enable` = write_needed && !illegal, with `csr_write_value` = new.
  - Go to RESP.
- RESP:
  - Assert `rsp_valid` to the owning requester only, with `rsp_data` = `old_value` and `rsp_illegal` = illegal.
  - Hold all three stable until `rsp_ready`, then go to IDLE.
- Output drive:
  - `csr_address` holds the latched address in READ, WRITE and RESP; it is 0 in IDLE.
  - `csr_write_value` is 0 outside WRITE.

## Timing
- Request accepted at cycle T. READ at T+1. Write strobe (if any) at T+2. `rsp_valid` first high at T+3.
- Minimum 4 cycles per access. Back-to-back accesses: next accept at the cycle after the response handshake, in IDLE.
- `*_req_ready` is high only in IDLE, so no request is accepted while an access is in flight.
- `rsp_ready` already high at T+3 retires the access that cycle; IDLE at T+4.
- Reset values:
  - State IDLE; `last_grant` = debug, so the first contended grant goes to core.
  - All ready, rsp_valid, rsp_illegal and `csr_write_enable` are 0.
  - `rsp_data`, `csr_address` and `csr_write_value` are 0.
- Reset asserted mid-access: immediate return to IDLE.
  - `csr_write_enable` drops asynchronously.
  - The pending response is discarded and no partial write occurs.
- Operand width: bitwise only, no carries. Exactly DATA_WIDTH bits.

## Configuration
- Macro `CSR_SEQ_DEBUG_PORT_EN`.
- Defined: the debug requester participates in round-robin arbitration as described.
- Undefined:
  - `dbg_req_ready`, `dbg_rsp_valid` and `dbg_rsp_illegal` are tied 0; `dbg_rsp_data` is 0.
  - `dbg_req_*` inputs are ignored; the core is always granted and `last_grant` logic is removed.
  - Ports remain present.

## Test plan
- Core RW to 0x340 with operand 0xDEADBEEF, while the CSR returns 0x12345678:
  - `csr_write_enable` high at T+2 with value 0xDEADBEEF.
  - `core_rsp_data` = 0x12345678 at T+3.
- Core RS to 0x300 with operand 0, read 0x88:
  - No write strobe.
  - `rsp_data` = 0x88; `rsp_illegal` = 0.
- Core RC to 0xF14 with operand 0x1:
  - No write strobe; `rsp_illegal` = 1.
  - Core RS to 0xF14 with operand 0 instead: legal, `rsp_illegal` = 0.
- Core and debug valid simultaneously for three requests each:
  - Grants alternate core, dbg, core, dbg, core, dbg.
  - Each response goes only to its owner.
- `rsp_ready` held low for 5 cycles:
  - `rsp_valid` and `rsp_data` stay stable.
  - No new request is accepted until the response handshake.
- `reset_n` pulsed low during WRITE:
  - `csr_write_enable` falls without a clock edge.
  - FSM returns to IDLE; no `rsp_valid` is issued.
  - With `CSR_SEQ_DEBUG_PORT_EN` undefined, debug requests are never granted.
